// File: rtl/frame_pkg.sv
// Shared definitions for the serial frame receiver: frame constants and FSM states.
package frame_pkg;
    localparam int         MAX_BYTES = 16;
    localparam int         SIZE_BITS = 4;
    localparam logic       START_BIT = 1'b1;
    localparam logic       STOP_BIT  = 1'b0;
    localparam logic [7:0] CRC_POLY  = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SIZE,
        ST_DATA,
        ST_CRC,
        ST_STOP,
        ST_DONE
    } state_t;
endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8, MSB first, no reflection; clear wins over enable.
module crc8_serial
    import frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [7:0] crc_out
);
    logic [7:0] crc_q;
    logic       fb;

    assign fb = crc_q[7] ^ bit_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      crc_q <= 8'h00;
        else if (clear)  crc_q <= 8'h00;
        else if (enable) crc_q <= {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    end

    assign crc_out = crc_q;
endmodule

// File: rtl/frame_receiver.sv
// Serial frame receiver: start, 4-bit size, 1-15 data bytes, CRC-8, stop; each bit
// held for baudrate cycles and sampled mid-bit after a 2-flop synchronizer.
module frame_receiver #(
    parameter int MAX_BYTES = frame_pkg::MAX_BYTES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   RX,
    input  logic [7:0]             baudrate,
    output logic                   RXI,
    output logic [3:0]             framesize,
    output logic [MAX_BYTES*8-1:0] framebits,
    output logic                   frame_valid,
    output logic                   crc_ok,
    output logic                   frame_err
);
    import frame_pkg::*;

    logic                   rx_meta_q, rx_s_q, rx_prev_q;
    state_t                 state_q, state_d;
    logic [7:0]             baud_q, baud_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [3:0]             byte_q, byte_d;
    logic [2:0]             size_sh_q, size_sh_d;
    logic [3:0]             framesize_q, framesize_d;
    logic [MAX_BYTES*8-1:0] framebits_q, framebits_d;
    logic [6:0]             rcrc_q, rcrc_d;
    logic                   crc_ok_q, crc_ok_d;
    logic                   err_q, err_d;
    logic                   crc_clr, crc_en;
    logic [7:0]             crc_val;
    logic [3:0]             size_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b0;
            rx_s_q    <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    crc8_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (crc_clr),
        .enable (crc_en),
        .bit_in (rx_s_q),
        .crc_out(crc_val)
    );

    assign size_new = {size_sh_q, rx_s_q};

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        size_sh_d   = size_sh_q;
        framesize_d = framesize_q;
        framebits_d = framebits_q;
        rcrc_d      = rcrc_q;
        crc_ok_d    = crc_ok_q;
        err_d       = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_s_q && !rx_prev_q && baudrate >= 8'd2) begin
                    // countdown hits zero exactly h cycles after the edge cycle
                    state_d     = ST_START;
                    baud_d      = baudrate;
                    cnt_d       = (baudrate >> 1) - 8'd1;
                    bit_d       = 3'd0;
                    byte_d      = 4'd0;
                    framebits_d = '0;
                    crc_ok_d    = 1'b0;
                    crc_clr     = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (cnt_q == 8'd0) begin
                    cnt_d = baud_q - 8'd1;
                    case (state_q)
                        ST_START: state_d = (rx_s_q == START_BIT) ? ST_SIZE : ST_IDLE;
                        ST_SIZE: begin
                            crc_en    = 1'b1;
                            size_sh_d = {size_sh_q[1:0], rx_s_q};
                            bit_d     = bit_q + 3'd1;
                            if (bit_q == 3'(SIZE_BITS - 1)) begin
                                framesize_d = size_new;
                                bit_d       = 3'd0;
                                if (size_new == 4'd0) begin
                                    err_d   = 1'b1;
                                    state_d = ST_IDLE;
                                end else begin
                                    state_d = ST_DATA;
                                end
                            end
                        end
                        ST_DATA: begin
                            // byte k, bit b lands at (15-k)*8 + (7-b)
                            crc_en                          = 1'b1;
                            framebits_d[{~byte_q, ~bit_q}]  = rx_s_q;
                            bit_d                           = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                if (byte_q == framesize_q - 4'd1) state_d = ST_CRC;
                                else                              byte_d  = byte_q + 4'd1;
                            end
                        end
                        ST_CRC: begin
                            rcrc_d = {rcrc_q[5:0], rx_s_q};
                            bit_d  = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                crc_ok_d = ({rcrc_q, rx_s_q} == crc_val);
                                state_d  = ST_STOP;
                            end
                        end
                        ST_STOP: begin
                            if (rx_s_q == STOP_BIT) begin
                                state_d = ST_DONE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            baud_q      <= 8'd0;
            cnt_q       <= 8'd0;
            bit_q       <= 3'd0;
            byte_q      <= 4'd0;
            size_sh_q   <= 3'd0;
            framesize_q <= 4'd0;
            framebits_q <= '0;
            rcrc_q      <= 7'd0;
            crc_ok_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            size_sh_q   <= size_sh_d;
            framesize_q <= framesize_d;
            framebits_q <= framebits_d;
            rcrc_q      <= rcrc_d;
            crc_ok_q    <= crc_ok_d;
            err_q       <= err_d;
        end
    end

    assign RXI         = (state_q == ST_IDLE);
    assign frame_valid = (state_q == ST_DONE);
    assign framesize   = framesize_q;
    assign framebits   = framebits_q;
    assign crc_ok      = crc_ok_q;
    assign frame_err   = err_q;
endmodule

// File: tb/tb_frame_receiver.sv
// Self-checking bench for frame_receiver: directed frames plus randomized frames
// checked against a behavioural frame/CRC model.
module tb_frame_receiver;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         RX = 1'b0;
    logic [7:0]   baudrate = 8'd0;
    logic         RXI, frame_valid, crc_ok, frame_err;
    logic [3:0]   framesize;
    logic [127:0] framebits;

    frame_receiver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .baudrate   (baudrate),
        .RXI        (RXI),
        .framesize  (framesize),
        .framebits  (framebits),
        .frame_valid(frame_valid),
        .crc_ok     (crc_ok),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0, n_pass = 0;
    int   fv_cnt = 0, fe_cnt = 0, fv_cyc = 0, fe_cyc = 0;
    logic fv_rxi = 1'b1, fv_rxi_next = 1'b0, fv_prev = 1'b0;

    always @(negedge clk) begin
        if (fv_prev) fv_rxi_next = RXI;
        fv_prev = frame_valid;
        if (frame_valid) begin fv_cnt++; fv_cyc = cyc; fv_rxi = RXI; end
        if (frame_err)   begin fe_cnt++; fe_cyc = cyc; end
    end

    logic [7:0] dat [16];
    logic       bits_q [$];
    int         t0;

    function automatic logic [7:0] crc_ref(input logic [3:0] sz, input int n);
        logic [7:0] c;
        logic [7:0] stream [$];
        c = 8'h00;
        stream.push_back({sz, 4'h0});
        for (int k = 0; k < n; k++) stream.push_back(dat[k]);
        for (int j = 0; j < stream.size(); j++)
            for (int i = 7; i >= ((j == 0) ? 4 : 0); i--)
                c = (c[7] ^ stream[j][i]) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        return c;
    endfunction

    function automatic logic [127:0] exp_fb(input int n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[127-8*k -: 8] = dat[k];
        return r;
    endfunction

    task automatic build(input logic [3:0] sz, input int n, input logic [7:0] crc, input logic stop);
        bits_q = {};
        bits_q.push_back(1'b1);
        for (int i = 3; i >= 0; i--) bits_q.push_back(sz[i]);
        for (int k = 0; k < n; k++)
            for (int i = 7; i >= 0; i--) bits_q.push_back(dat[k][i]);
        for (int i = 7; i >= 0; i--) bits_q.push_back(crc[i]);
        bits_q.push_back(stop);
    endtask

    task automatic play(input int b, input int nbits);
        baudrate = 8'(b);
        @(posedge clk); #1;
        t0 = cyc;
        for (int i = 0; i < nbits; i++) begin
            RX = bits_q[i];
            repeat (b) begin @(posedge clk); #1; end
        end
        RX = 1'b0;
    endtask

    task automatic clear_mon();
        fv_cnt = 0; fe_cnt = 0; fv_cyc = -1; fe_cyc = -1;
        fv_rxi = 1'b1; fv_rxi_next = 1'b0;
    endtask

    task automatic settle(input int b);
        repeat (2*b + 6) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (RXI !== 1'b1) $display("FAIL reset_rxi: got %b want 1", RXI); else n_pass++;
        n_chk++; if (framesize !== 4'd0 || framebits !== 128'd0)
            $display("FAIL reset_data: got size %h bits %h want 0", framesize, framebits); else n_pass++;
        n_chk++; if ({frame_valid, crc_ok, frame_err} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {frame_valid, crc_ok, frame_err}); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_good_frame();
        dat[0] = 8'hA5;
        build(4'd1, 1, 8'h67, 1'b0);
        clear_mon();
        play(4, bits_q.size());
        settle(4);
        n_chk++; if (fv_cnt !== 1 || fe_cnt !== 0)
            $display("FAIL good_pulses: got fv %0d fe %0d want 1 0", fv_cnt, fe_cnt); else n_pass++;
        n_chk++; if (fv_cyc !== t0 + 89)
            $display("FAIL good_latency: got %0d want %0d", fv_cyc - t0, 89); else n_pass++;
        n_chk++; if (framebits !== {8'hA5, 120'd0} || framesize !== 4'd1)
            $display("FAIL good_data: got %h/%0d want a5../1", framebits, framesize); else n_pass++;
        n_chk++; if (crc_ok !== 1'b1) $display("FAIL good_crc: got %b want 1", crc_ok); else n_pass++;
        n_chk++; if (fv_rxi !== 1'b0 || fv_rxi_next !== 1'b1)
            $display("FAIL good_rxi: got %b%b want 01", fv_rxi, fv_rxi_next); else n_pass++;
    endtask

    task automatic test_bad_crc();
        dat[0] = 8'hA5;
        build(4'd1, 1, 8'h66, 1'b0);
        clear_mon();
        play(4, bits_q.size());
        settle(4);
        n_chk++; if (fv_cnt !== 1 || fe_cnt !== 0)
            $display("FAIL badcrc_pulses: got fv %0d fe %0d want 1 0", fv_cnt, fe_cnt); else n_pass++;
        n_chk++; if (crc_ok !== 1'b0) $display("FAIL badcrc_flag: got %b want 0", crc_ok); else n_pass++;
        n_chk++; if (framebits[127:120] !== 8'hA5)
            $display("FAIL badcrc_data: got %h want a5", framebits[127:120]); else n_pass++;
    endtask

    task automatic test_max_frame();
        for (int k = 0; k < 15; k++) dat[k] = 8'(k + 1);
        build(4'd15, 15, crc_ref(4'd15, 15), 1'b0);
        clear_mon();
        play(3, bits_q.size());
        settle(3);
        n_chk++; if (framebits !== exp_fb(15))
            $display("FAIL max_data: got %h want %h", framebits, exp_fb(15)); else n_pass++;
        n_chk++; if (framebits[7:0] !== 8'h00) $display("FAIL max_byte15: got %h want 00", framebits[7:0]); else n_pass++;
        n_chk++; if (framesize !== 4'd15 || crc_ok !== 1'b1 || fv_cnt !== 1)
            $display("FAIL max_status: got size %0d crc %b fv %0d want 15 1 1", framesize, crc_ok, fv_cnt); else n_pass++;
        n_chk++; if (fv_cyc !== t0 + 2 + 1 + (13 + 8*15)*3 + 1)
            $display("FAIL max_latency: got %0d want %0d", fv_cyc - t0, 2 + 1 + 133*3 + 1); else n_pass++;
    endtask

    task automatic test_glitch();
        clear_mon();
        baudrate = 8'd8;
        @(posedge clk); #1; RX = 1'b1;
        @(posedge clk); #1; RX = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_chk++; if (RXI !== 1'b0) $display("FAIL glitch_busy: got RXI %b want 0", RXI); else n_pass++;
        repeat (12) @(posedge clk);
        @(negedge clk);
        n_chk++; if (RXI !== 1'b1 || fv_cnt !== 0 || fe_cnt !== 0)
            $display("FAIL glitch_idle: got RXI %b fv %0d fe %0d want 1 0 0", RXI, fv_cnt, fe_cnt); else n_pass++;
    endtask

    task automatic test_low_baud();
        clear_mon();
        baudrate = 8'd1;
        @(posedge clk); #1; RX = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        n_chk++; if (RXI !== 1'b1) $display("FAIL lowbaud_idle: got RXI %b want 1", RXI); else n_pass++;
        RX = 1'b0;
        settle(2);
    endtask

    task automatic test_size_zero();
        build(4'd0, 0, 8'h00, 1'b0);
        clear_mon();
        play(5, bits_q.size());
        settle(5);
        n_chk++; if (fe_cnt !== 1 || fv_cnt !== 0)
            $display("FAIL size0_pulses: got fe %0d fv %0d want 1 0", fe_cnt, fv_cnt); else n_pass++;
        n_chk++; if (fe_cyc !== t0 + 2 + 2 + 4*5 + 1)
            $display("FAIL size0_timing: got %0d want %0d", fe_cyc - t0, 25); else n_pass++;
    endtask

    task automatic test_bad_stop();
        dat[0] = 8'($urandom); dat[1] = 8'($urandom);
        build(4'd2, 2, crc_ref(4'd2, 2), 1'b1);
        clear_mon();
        play(4, bits_q.size());
        settle(4);
        n_chk++; if (fe_cnt !== 1 || fv_cnt !== 0)
            $display("FAIL stop_pulses: got fe %0d fv %0d want 1 0", fe_cnt, fv_cnt); else n_pass++;
        n_chk++; if (fe_cyc !== t0 + 2 + 2 + (13 + 16)*4 + 1)
            $display("FAIL stop_timing: got %0d want %0d", fe_cyc - t0, 4 + 29*4 + 1); else n_pass++;
        n_chk++; if (RXI !== 1'b1) $display("FAIL stop_idle: got %b want 1", RXI); else n_pass++;
    endtask

    task automatic test_mid_reset();
        dat[0] = 8'hFF; dat[1] = 8'h3C; dat[2] = 8'h81;
        build(4'd3, 3, crc_ref(4'd3, 3), 1'b0);
        clear_mon();
        play(4, 5 + 12);
        RX = 1'b1;
        rst_n = 1'b0;
        #1;
        n_chk++; if (RXI !== 1'b1 || framesize !== 4'd0 || framebits !== 128'd0 || crc_ok !== 1'b0)
            $display("FAIL midrst_outputs: got RXI %b size %0d bits %h crc %b want 1 0 0 0",
                     RXI, framesize, framebits, crc_ok); else n_pass++;
        RX = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_chk++; if (fv_cnt !== 0 || fe_cnt !== 0)
            $display("FAIL midrst_pulses: got fv %0d fe %0d want 0 0", fv_cnt, fe_cnt); else n_pass++;
        dat[0] = 8'h5A; dat[1] = 8'hC3;
        build(4'd2, 2, crc_ref(4'd2, 2), 1'b0);
        clear_mon();
        play(4, bits_q.size());
        settle(4);
        n_chk++; if (fv_cnt !== 1 || framebits !== exp_fb(2) || crc_ok !== 1'b1 || framesize !== 4'd2)
            $display("FAIL midrst_recover: got fv %0d bits %h crc %b size %0d", fv_cnt, framebits, crc_ok, framesize);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int         b, n;
            logic [7:0] crc;
            logic       want_ok;
            b = int'($urandom_range(2, 7));
            n = int'($urandom_range(1, 15));
            for (int k = 0; k < 16; k++) dat[k] = 8'($urandom);
            crc = crc_ref(4'(n), n);
            want_ok = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                crc = crc ^ (8'd1 << $urandom_range(0, 7));
                want_ok = 1'b0;
            end
            build(4'(n), n, crc, 1'b0);
            clear_mon();
            play(b, bits_q.size());
            settle(b);
            n_chk++; if (fv_cnt !== 1 || fe_cnt !== 0)
                $display("FAIL rand%0d_pulses: got fv %0d fe %0d want 1 0", it, fv_cnt, fe_cnt); else n_pass++;
            n_chk++; if (framebits !== exp_fb(n) || framesize !== 4'(n))
                $display("FAIL rand%0d_data: got %h/%0d want %h/%0d", it, framebits, framesize, exp_fb(n), n);
            else n_pass++;
            n_chk++; if (crc_ok !== want_ok) $display("FAIL rand%0d_crc: got %b want %b", it, crc_ok, want_ok); else n_pass++;
            n_chk++; if (fv_cyc !== t0 + 2 + b/2 + (13 + 8*n)*b + 1)
                $display("FAIL rand%0d_latency: got %0d want %0d", it, fv_cyc - t0, 2 + b/2 + (13 + 8*n)*b + 1);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_max_frame();
        test_glitch();
        test_low_baud();
        test_size_zero();
        test_bad_stop();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/frame_receiver.md
# frame_receiver

Serial frame receiver; the stage directly downstream of the frame transmitter. It recovers the serial frame: start bit, 4-bit frame size, 1–15 data bytes, CRC-8 byte, stop bit. Each bit is held on the line for `baudrate` clock cycles. The block delivers the frame size and data bytes in parallel with CRC and framing status, so frame consumers see the same `framesize`/`framebits` layout the transmitter takes as input.

## Interface
- `MAX_BYTES`, default 16: width of `framebits` in bytes. Fixed by the frame format; not to be overridden.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `RX` in 1: serial line; idle level 0.
- `baudrate` in 8: clock cycles per bit; captured at start detect; values <2 keep the block idle.
- `RXI` out 1: receiver idle; high in IDLE, low from start detect until return to IDLE.
- `framesize` out 4: received byte count; held until next frame's size field completes.
- `framebits` out 128: byte k at [(15-k)*8+7 : (15-k)*8], MSB first; unused bytes zero.
- `frame_valid` out 1: one-cycle pulse, frame complete.
- `crc_ok` out 1: valid with `frame_valid`; held until next start detect.
- `frame_err` out 1: one-cycle pulse on framing failure.

## Operation
- Line format: start bit = 1, then size (MSB first), then data, then CRC (MSB first), then stop bit = 0.
- `RX` passes through a 2-flop synchronizer (rx_s). Start detect is an rx_s 0→1 transition in IDLE with captured `baudrate` ≥ 2.
- States and transitions:
  - IDLE → START on start detect.
  - START: sample at cycle h = baudrate>>1. If rx_s = 0, treat as a glitch: → IDLE, no flags. Otherwise → SIZE.
  - SIZE: 4 samples, one every `baudrate` cycles. Size 0 → `frame_err` pulse, → IDLE. Else → DATA.
  - DATA: framesize×8 samples into byte k, bit 7 first. → CRC.
  - CRC: 8 samples compared against the computed CRC. → STOP.
  - STOP: one sample. Stop bit 0 → DONE. Stop bit 1 → `frame_err` pulse, `frame_valid` not asserted, → IDLE.
  - DONE: `frame_valid` pulse for one cycle, → IDLE.
- CRC-8:
  - Polynomial 0x07, init 0x00, no reflection, serial MSB first.
  - Covers the 4 size bits plus all data bits.
  - `crc_ok` = received CRC byte equals computed CRC.
- On start detect:
  - `framebits` cleared to 0.
  - CRC reset.
  - `crc_ok` cleared.
- Counters:
  - baud counter 8-bit, reloads each bit.
  - bit counter 3-bit, wraps 0→7 across bytes.
  - byte counter 4-bit, compared against `framesize`−1.
- A new start edge during a frame is ignored.
- Reset asserted mid-frame aborts the frame with no pulses.

## Timing
- Reset values:
  - `RXI` = 1.
  - `framesize` = 0.
  - `framebits` = 0.
  - `frame_valid` = 0.
  - `crc_ok` = 0.
  - `frame_err` = 0.
  - state = IDLE.
- Sample points are measured from the rx_s rising edge at cycle 0. Bit index i is sampled at cycle h + i·baudrate.
- Bit indices: start = 0, size = 1–4, data = 5…4+8N, CRC = 5+8N…12+8N, stop = 13+8N.
- `frame_valid` asserts at cycle h + (13+8N)·baudrate + 1. `RXI` rises in the same cycle the pulse deasserts.
- Input-pin-to-rx_s latency is 2 cycles.
- `framebits` and `framesize` are stable from the `frame_valid` cycle until the next start detect.
- `frame_err` asserts 1 cycle after the offending sample.

## Structure
- Package `frame_pkg`:
  - state enum.
  - START_BIT = 1, STOP_BIT = 0.
  - CRC_POLY = 8'h07.
  - MAX_BYTES = 16.
  - `SIZE_BITS` = 4.
- Sub-module `crc8_serial`:
  - ports: clk, rst_n, clear, enable, bit_in, crc_out[7:0].
  - shift rule: fb = crc[7]^bit_in; crc ← {crc[6:0],0} ^ (fb ? 0x07 : 0).

## Test plan
- Good 1-byte frame: baudrate 4, size 1, data 0xA5, CRC 0x67 → `framebits[127:120]` = 0xA5, rest 0. `framesize` = 1, `crc_ok` = 1, `frame_valid` at cycle 2+4·21+1 = 87 after the edge.
- Corrupted CRC: same frame with CRC 0x66 → `frame_valid` pulse with `crc_ok` = 0, data still 0xA5.
- Max frame: baudrate 3, size 15, data bytes 0x01…0x0F → bytes in order at k = 0…14, byte 15 = 0, `crc_ok` = 1.
- Start glitch: RX high for 1 cycle at baudrate 8 → back to IDLE, `RXI` = 1, no pulses.
- Bad framing, two stimuli:
  - size field 0 → `frame_err` pulse, `frame_valid` never asserts.
  - stop bit sent as 1 → `frame_err` pulse, `frame_valid` never asserts.
- Mid-frame reset: `rst_n` low during DATA → all outputs reset immediately; the next good frame is received correctly.
